// File: rtl/systolic_input_skewer_if.sv
// Bus bundle between the row selector / matrix memory side and the input skewer.
// The slave modport is the skewer's view; the master modport is the environment's.
interface systolic_input_skewer_if #(
  parameter int unsigned SYSTOLIC_WIDTH = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8
);
  logic                               start_in;
  logic                               stop_in;
  logic [ADDR_WIDTH-1:0]              addr_in;
  logic                               addr_valid_in;
  logic [ADDR_WIDTH-1:0]              mem_addr_out;
  logic [DATA_WIDTH-1:0]              mem_data_in;
  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] lanes_out;
  logic [SYSTOLIC_WIDTH-1:0]          lanes_valid_out;
  logic                               busy_out;
  logic                               done_out;

  modport master (
    output start_in, stop_in, addr_in, addr_valid_in, mem_data_in,
    input  mem_addr_out, lanes_out, lanes_valid_out, busy_out, done_out
  );

  modport slave (
    input  start_in, stop_in, addr_in, addr_valid_in, mem_data_in,
    output mem_addr_out, lanes_out, lanes_valid_out, busy_out, done_out
  );
endinterface

// File: rtl/systolic_input_skewer.sv
// Fetches one matrix row element per slot, assembles SYSTOLIC_WIDTH-element groups
// and launches each group diagonally (lane k delayed by k cycles) into the array.
module systolic_input_skewer #(
  parameter int unsigned SYSTOLIC_WIDTH = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  systolic_input_skewer_if.slave skew_if
);

  localparam int unsigned LANE_W = (SYSTOLIC_WIDTH > 1) ? $clog2(SYSTOLIC_WIDTH) : 1;
  localparam int unsigned FCNT_W = $clog2(SYSTOLIC_WIDTH + 2);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(SYSTOLIC_WIDTH - 1);
  localparam logic [FCNT_W-1:0] LAST_FLUSH = FCNT_W'(SYSTOLIC_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLUSH
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LANE_W-1:0]   r_lane;
  logic [FCNT_W-1:0]   r_fcnt;
  logic                r_pad;
  logic                r_done;
  logic                w_real;
  logic                w_done_nxt;

  logic                r_rd_slot;
  logic                r_rd_real;
  logic [LANE_W-1:0]   r_rd_lane;
  logic [DATA_WIDTH-1:0] w_elem;
  logic [DATA_WIDTH-1:0] r_col     [SYSTOLIC_WIDTH];
  logic [DATA_WIDTH-1:0] w_col_nxt [SYSTOLIC_WIDTH];
  logic [DATA_WIDTH-1:0] r_grp     [SYSTOLIC_WIDTH];
  logic                  r_grp_valid;

  logic [DATA_WIDTH-1:0] w_lane_d [SYSTOLIC_WIDTH];
  logic [SYSTOLIC_WIDTH-1:0] w_lane_v;
  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] w_lanes;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_real      = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (skew_if.start_in) w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        w_real = skew_if.addr_valid_in && !r_pad;
        // a stop on the last-lane slot still lets that slot through, then closes the group
        if ((r_lane == LAST_LANE) && (r_pad || skew_if.stop_in)) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_fcnt == LAST_FLUSH) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_lane <= '0;
      r_pad  <= 1'b0;
      r_fcnt <= '0;
    end else begin
      if (r_state != ST_FILL) begin
        r_lane <= '0;
        r_pad  <= 1'b0;
      end else begin
        r_lane <= (r_lane == LAST_LANE) ? '0 : r_lane + 1'b1;
        if (skew_if.stop_in) r_pad <= 1'b1;
      end
      r_fcnt <= (r_state == ST_FLUSH) ? r_fcnt + 1'b1 : '0;
    end
  end

  assign skew_if.mem_addr_out = w_real ? skew_if.addr_in : '0;
  assign skew_if.busy_out     = (r_state != ST_IDLE);
  assign skew_if.done_out     = r_done;

  assign w_elem = r_rd_real ? skew_if.mem_data_in : '0;

  always_comb begin
    w_col_nxt            = r_col;
    w_col_nxt[r_rd_lane] = w_elem;
  end

  // Group register takes the collect vector including the element arriving this cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rd_slot   <= 1'b0;
      r_rd_real   <= 1'b0;
      r_rd_lane   <= '0;
      r_col       <= '{default: '0};
      r_grp       <= '{default: '0};
      r_grp_valid <= 1'b0;
    end else begin
      r_rd_slot   <= (r_state == ST_FILL);
      r_rd_real   <= w_real;
      r_rd_lane   <= r_lane;
      r_grp_valid <= 1'b0;
      if (r_rd_slot) begin
        r_col <= w_col_nxt;
        if (r_rd_lane == LAST_LANE) begin
          r_grp       <= w_col_nxt;
          r_grp_valid <= 1'b1;
        end
      end
    end
  end

  assign w_lane_d[0] = r_grp[0];
  assign w_lane_v[0] = r_grp_valid;

  for (genvar k = 1; k < SYSTOLIC_WIDTH; k++) begin : g_skew
    logic [DATA_WIDTH-1:0] r_pipe [k];
    logic [k-1:0]          r_vpipe;

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_pipe  <= '{default: '0};
        r_vpipe <= '0;
      end else begin
        r_pipe[0]  <= r_grp[k];
        r_vpipe[0] <= r_grp_valid;
        for (int unsigned s = 1; s < k; s++) begin
          r_pipe[s]  <= r_pipe[s-1];
          r_vpipe[s] <= r_vpipe[s-1];
        end
      end
    end

    assign w_lane_d[k] = r_pipe[k-1];
    assign w_lane_v[k] = r_vpipe[k-1];
  end

  always_comb begin
    w_lanes = '0;
    for (int unsigned k = 0; k < SYSTOLIC_WIDTH; k++) begin
      if (w_lane_v[k]) w_lanes[k*DATA_WIDTH +: DATA_WIDTH] = w_lane_d[k];
    end
  end

  assign skew_if.lanes_out       = w_lanes;
  assign skew_if.lanes_valid_out = w_lane_v;

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Randomized bench for systolic_input_skewer: per-pass expectations are derived from
// slot/group arithmetic (slot i -> group i/W, lane i%W, output at group end + 2 + lane).
module tb_systolic_input_skewer;
  localparam int unsigned SW = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int SWI  = SW;
  localparam int DWI  = DW;
  localparam int MAXC = 64;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  systolic_input_skewer_if #(.SYSTOLIC_WIDTH(SW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  systolic_input_skewer #(.SYSTOLIC_WIDTH(SW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .skew_if(bus)
  );

  always #5 clk_in = ~clk_in;

  // Matrix memory: mem[a] = a + 16, one-cycle synchronous read.
  always @(posedge clk_in) bus.mem_data_in <= DW'(bus.mem_addr_out) + DW'(16);

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0]    s_addr  [MAXC];
  logic             s_valid [MAXC];
  logic             s_stop  [MAXC];
  logic             s_start [MAXC];
  logic [SW-1:0]    e_valid [MAXC];
  logic [SW*DW-1:0] e_lanes [MAXC];
  logic             e_busy  [MAXC];
  logic             e_done  [MAXC];
  logic [AW-1:0]    e_maddr [MAXC];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int done_cycle(input int stop_slot);
    return 1 + (stop_slot / SWI + 1) * SWI + SWI + 1;
  endfunction

  task automatic fill_stim(input int stop_slot, input bit extra_starts);
    int dc;
    dc = done_cycle(stop_slot);
    for (int c = 0; c < MAXC; c++) begin
      s_addr[c]  = AW'($urandom);
      s_valid[c] = ($urandom_range(0, 3) != 0);
      s_stop[c]  = 1'b0;
      s_start[c] = extra_starts && (c > 0) && (c < dc) && ($urandom_range(0, 4) == 0);
    end
    s_start[0]             = 1'b1;
    s_stop[1 + stop_slot]  = 1'b1;
  endtask

  task automatic set_single_group();
    s_addr[1] = 8'd3; s_valid[1] = 1'b1;
    s_addr[2] = 8'd4; s_valid[2] = 1'b1;
  endtask

  task automatic build_expect(input int stop_slot);
    int n_slots, g, ln, t, oc, dc;
    logic rl;
    logic [DW-1:0] el;
    n_slots = (stop_slot / SWI + 1) * SWI;
    dc      = done_cycle(stop_slot);
    for (int c = 0; c < MAXC; c++) begin
      e_valid[c] = '0;
      e_lanes[c] = '0;
      e_busy[c]  = (c >= 1) && (c < dc);
      e_done[c]  = (c == dc);
      e_maddr[c] = '0;
    end
    for (int i = 0; i < n_slots; i++) begin
      g  = i / SWI;
      ln = i % SWI;
      rl = s_valid[1 + i] && (i <= stop_slot);
      e_maddr[1 + i] = rl ? s_addr[1 + i] : '0;
      el = rl ? DW'(s_addr[1 + i] + 16) : '0;
      t  = 1 + g * SWI + SWI - 1;
      oc = t + 2 + ln;
      e_valid[oc][ln]              = 1'b1;
      e_lanes[oc][ln*DWI +: DWI]   = el;
    end
  endtask

  task automatic drive_cycle(input int c);
    @(posedge clk_in);
    #1;
    bus.start_in      = s_start[c];
    bus.stop_in       = s_stop[c];
    bus.addr_in       = s_addr[c];
    bus.addr_valid_in = s_valid[c];
  endtask

  task automatic check_cycle(input int c);
    check_eq($sformatf("c%0d lanes_valid", c), 64'(bus.lanes_valid_out), 64'(e_valid[c]));
    check_eq($sformatf("c%0d lanes", c),       64'(bus.lanes_out),       64'(e_lanes[c]));
    check_eq($sformatf("c%0d busy", c),        64'(bus.busy_out),        64'(e_busy[c]));
    check_eq($sformatf("c%0d done", c),        64'(bus.done_out),        64'(e_done[c]));
    check_eq($sformatf("c%0d mem_addr", c),    64'(bus.mem_addr_out),    64'(e_maddr[c]));
  endtask

  task automatic run_pass(input int n_cyc);
    for (int c = 0; c < n_cyc; c++) begin
      drive_cycle(c);
      @(negedge clk_in);
      check_cycle(c);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " lanes"},       64'(bus.lanes_out),       64'd0);
    check_eq({tag, " lanes_valid"}, 64'(bus.lanes_valid_out), 64'd0);
    check_eq({tag, " busy"},        64'(bus.busy_out),        64'd0);
    check_eq({tag, " done"},        64'(bus.done_out),        64'd0);
    check_eq({tag, " mem_addr"},    64'(bus.mem_addr_out),    64'd0);
  endtask

  // Reset asserted between edges in cycle rst_at, held for two cycles, then the
  // block must stay silent without a fresh start.
  task automatic run_with_reset(input int rst_at);
    for (int c = 0; c < rst_at; c++) begin
      drive_cycle(c);
      @(negedge clk_in);
      check_cycle(c);
    end
    drive_cycle(rst_at);
    #1;
    check_eq("pre-reset lanes_valid", 64'(bus.lanes_valid_out), 64'(e_valid[rst_at]));
    check_eq("pre-reset busy",        64'(bus.busy_out),        64'(e_busy[rst_at]));
    #1;
    rst_in       = 1'b0;
    bus.start_in = 1'b0;
    #1;
    check_reset_outputs("async-reset");
    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    for (int q = 0; q < 10; q++) begin
      @(negedge clk_in);
      check_eq($sformatf("quiet%0d lanes_valid", q), 64'(bus.lanes_valid_out), 64'd0);
      check_eq($sformatf("quiet%0d done", q),        64'(bus.done_out),        64'd0);
      check_eq($sformatf("quiet%0d busy", q),        64'(bus.busy_out),        64'd0);
      check_eq($sformatf("quiet%0d mem_addr", q),    64'(bus.mem_addr_out),    64'd0);
      @(posedge clk_in);
      #1;
      bus.addr_in       = AW'($urandom);
      bus.addr_valid_in = 1'($urandom);
      bus.stop_in       = 1'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ss;
    bus.start_in      = 1'b0;
    bus.stop_in       = 1'b0;
    bus.addr_in       = '0;
    bus.addr_valid_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    bus.addr_in       = 8'h5a;
    bus.addr_valid_in = 1'b1;
    @(negedge clk_in);
    check_reset_outputs("reset");
    #2;
    rst_in            = 1'b1;
    bus.addr_valid_in = 1'b0;

    // single group
    fill_stim(1, 1'b0); set_single_group(); build_expect(1);
    run_pass(done_cycle(1) + 2);

    // padding: second slot not valid
    fill_stim(1, 1'b0); s_addr[1] = 8'd3; s_valid[1] = 1'b1; s_valid[2] = 1'b0;
    build_expect(1);
    run_pass(done_cycle(1) + 2);

    // stop on a lane-0 slot: the following lane-1 slot is padded even though valid
    fill_stim(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s_addr[1 + i]  = AW'(i);
      s_valid[1 + i] = 1'b1;
    end
    s_addr[4] = 8'd9; s_valid[4] = 1'b1;
    build_expect(2);
    run_pass(done_cycle(2) + 2);

    // start while busy is ignored
    fill_stim(1, 1'b0); set_single_group(); s_start[2] = 1'b1; build_expect(1);
    run_pass(done_cycle(1) + 2);

    // reset in the middle of FILL, then a fresh pass
    fill_stim(1, 1'b0); set_single_group(); build_expect(1);
    run_with_reset(2);
    fill_stim(1, 1'b0); set_single_group(); build_expect(1);
    run_pass(done_cycle(1) + 2);

    // reset while lanes are actively strobing
    fill_stim(9, 1'b1); build_expect(9);
    run_with_reset(7);

    // randomized passes
    repeat (24) begin
      ss = int'($urandom_range(0, 9));
      fill_stim(ss, 1'b1);
      build_expect(ss);
      run_pass(done_cycle(ss) + 2 + int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
